if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
Instruction-fetch stage; the producer that feeds the IF/ID pipeline register.
- Holds the PC and issues word fetches to the memory controller over a req/valid handshake.
- Buffers the returned instruction and presents it with its PC and next-PC prediction.
- Honours stall and branch/jump redirects from EX, including discarding in-flight fetches after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
BHT_IDX_W, 6, log2 of BHT entries (used only with IF_BPRED_EN)

Ports:
clk_in  in  1  clock, rising edge
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global ready; 0 freezes all state
stall_in  in  [`stallRange]  pipeline stall vector; bit 1 = IF stall
pcJump_in  in  1  redirect request from EX (`Jump)
pcTarget_in  in  [`addrRange]  redirect target
memReq_out  out  1  fetch request to memory controller
memAddr_out  out  [`addrRange]  fetch address, word aligned
memValid_in  in  1  one-cycle pulse: memInst_in valid
memInst_in  in  [`instRange]  fetched instruction
IF_stallReq_out  out  1  IF waiting on memory
instE_out  out  1  buffered instruction valid
pc_out  out  [`addrRange]  PC of buffered instruction
inst_out  out  [`instRange]  buffered instruction
IF_taken_out  out  1  predicted taken
IF_pcPred_out  out  [`addrRange]  predicted next PC
bpUpdE_in  in  1  BHT update strobe from EX
bpUpdPc_in  in  [`addrRange]  PC of resolved branch
bpUpdTaken_in  in  1  resolved direction

Behaviour:
- Reset (async, rst_n_in=0): pc=RESET_PC; state=IDLE; memReq_out=0, memAddr_out=0, IF_stallReq_out=0, instE_out=0, pc_out=0, inst_out=0, IF_taken_out=0, IF_pcPred_out=0.
- Reset mid-fetch aborts without waiting; the memory controller is reset by the same net. BHT counters reset to 2'b01.
- rdy_in=0: no register changes; memory inputs are ignored that cycle.
- States: IDLE, WAIT, HOLD, DROP.
- IDLE: memReq_out<=1, memAddr_out<=pc; go to WAIT.
- WAIT:
  - memReq_out and memAddr_out are held stable.
  - IF_stallReq_out=1 (combinational, WAIT or DROP).
  - On memValid_in: memReq_out<=0; inst_out<=memInst_in; pc_out<=pc; IF_taken_out/IF_pcPred_out<=prediction; instE_out<=1; go to HOLD.
  - Latency: instE_out rises the cycle after memValid_in.
- HOLD:
  - stall_in[1]==`Stall: all outputs held.
  - Otherwise: pc<=IF_pcPred_out; instE_out<=0; go to IDLE.
  - Steady-state throughput is one instruction per (mem latency + 2) cycles.
- DROP: memReq_out<=0. Wait for memValid_in, discard the data, then go to IDLE with the redirected pc.
- pcJump_in has priority over stall and all state actions:
  - pc<=pcTarget_in; instE_out<=0; IF_taken_out<=0.
  - From WAIT without memValid_in: go to DROP.
  - From WAIT with memValid_in in the same cycle: discard the data, memReq_out<=0, go to IDLE.
  - From IDLE or HOLD: go to IDLE.
  - From DROP: stay in DROP, with only pc updated.
- Prediction without bpred: IF_taken_out=0; IF_pcPred_out=pc+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
- Memory addresses are always pc with [1:0]=0.

Optional Feature:
IF_BPRED_EN
- Defined:
  - Predecode memInst_in:
    - JAL (opcode 7'b1101111): taken=1, target=pc+J-imm.
    - BRANCH (opcode 7'b1100011): taken=BHT[pc[BHT_IDX_W+1:2]][1], target=pc+B-imm.
    - Otherwise not taken.
  - IF_pcPred_out = taken ? target : pc+4.
  - bpUpdE_in saturating-increments or decrements the entry at bpUpdPc_in.
  - An update and a lookup of the same entry in one cycle: the lookup sees the old value.
- Undefined: no BHT storage; bpUpd* ports are ignored; static not-taken.

Decomposition:
- Shared defines package (defines.vh): `stallRange, `addrRange, `instRange, `ZERO32, `Jump, `Stall, `Disable, opcode constants OPC_JAL/OPC_BRANCH, IF state encoding.
- One sub-module, if_bpred: BHT, predecode and target adders, instantiated only under IF_BPRED_EN.

Test Plan:
1. Reset release, memory returns 32'h00000013 two cycles after req -> memAddr_out=0, instE_out=1 with pc_out=0, IF_pcPred_out=4; next req to addr 4.
2. HOLD with stall_in[1]=1 for 3 cycles -> outputs unchanged, no new req; stall drops -> req to pc+4 after one IDLE cycle.
3. pcJump_in with target 32'h100 while WAIT on addr 8 -> DROP; late memValid data discarded, instE_out stays 0; next req addr=32'h100.
4. pcJump_in in the same cycle as memValid_in -> data discarded, state IDLE, next req addr=target, no DROP.
5. rdy_in=0 for 4 cycles mid-WAIT -> no state/output change; resumes correctly. Async reset asserted mid-WAIT -> all outputs 0 immediately.
6. IF_BPRED_EN: BNE at 32'h40 with offset -16, after two taken updates -> IF_taken_out=1, IF_pcPred_out=32'h30. JAL at 32'h50 offset +8 -> IF_pcPred_out=32'h58.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, control
// encodings, opcode constants, the IF state encoding and immediate helpers.
package if_fetch_pkg;

   localparam int ADDR_W       = 32;
   localparam int INST_W       = 32;
   localparam int STALL_W      = 6;
   localparam int STALL_IF_BIT = 1;

   localparam logic [31:0] ZERO32  = 32'h0000_0000;
   localparam logic        JUMP    = 1'b1;
   localparam logic        STALL   = 1'b1;
   localparam logic        DISABLE = 1'b0;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_WAIT = 2'd1,
      IF_HOLD = 2'd2,
      IF_DROP = 2'd3
   } if_state_e;

   // Memory is word addressed; the low two PC bits never reach the bus.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

   // Sign-extended JAL immediate.
   function automatic logic [ADDR_W-1:0] imm_j(input logic [INST_W-1:0] i);
      return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   // Sign-extended conditional-branch immediate.
   function automatic logic [ADDR_W-1:0] imm_b(input logic [INST_W-1:0] i);
      return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/if_fetch_bpred.sv
// Branch predictor for the fetch stage: a table of 2-bit saturating counters
// indexed by PC word bits, plus predecode of JAL / conditional branches and
// their target adders. Only instantiated when IF_BPRED_EN is defined.
module if_bpred
   import if_fetch_pkg::*;
#(
   parameter int unsigned BHT_IDX_W = 6
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              rdy_in,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [INST_W-1:0] inst_in,
   input  logic              upd_e_in,
   input  logic [ADDR_W-1:0] upd_pc_in,
   input  logic              upd_taken_in,
   output logic              taken_out,
   output logic [ADDR_W-1:0] pred_pc_out
);

   localparam int unsigned BHT_N = 1 << BHT_IDX_W;

   logic [1:0]           r_bht [BHT_N];
   logic [BHT_IDX_W-1:0] w_lk_idx;
   logic [BHT_IDX_W-1:0] w_up_idx;
   logic [6:0]           w_opcode;
   logic                 w_unused_upd;

   assign w_lk_idx     = pc_in[BHT_IDX_W+1:2];
   assign w_up_idx     = upd_pc_in[BHT_IDX_W+1:2];
   assign w_opcode     = inst_in[6:0];
   assign w_unused_upd = ^{upd_pc_in[ADDR_W-1:BHT_IDX_W+2], upd_pc_in[1:0]};

   // Counter table: resolved branches nudge their counter toward the outcome,
   // saturating at both ends. A same-cycle lookup reads the pre-update value.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < int'(BHT_N); i++) begin
            r_bht[i] <= 2'b01;
         end
      end else if (rdy_in && upd_e_in) begin
         if (upd_taken_in) begin
            if (r_bht[w_up_idx] != 2'b11) r_bht[w_up_idx] <= r_bht[w_up_idx] + 2'b01;
         end else begin
            if (r_bht[w_up_idx] != 2'b00) r_bht[w_up_idx] <= r_bht[w_up_idx] - 2'b01;
         end
      end
   end

   // Predecode the returning instruction and pick the predicted next PC.
   always_comb begin
      taken_out   = 1'b0;
      pred_pc_out = pc_in + 32'd4;
      if (w_opcode == OPC_JAL) begin
         taken_out   = 1'b1;
         pred_pc_out = pc_in + imm_j(inst_in);
      end else if (w_opcode == OPC_BRANCH) begin
         taken_out = r_bht[w_lk_idx][1];
         if (r_bht[w_lk_idx][1]) pred_pc_out = pc_in + imm_b(inst_in);
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage feeding the IF/ID register. Issues one word fetch
// at a time, buffers the returned instruction with its PC and predicted next
// PC, and handles stalls and EX redirects (including squashing a fetch that
// is already in flight). Optional dynamic prediction: IF_BPRED_EN.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned       BHT_IDX_W = 6
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               rdy_in,
   input  logic [STALL_W-1:0] stall_in,
   input  logic               pcJump_in,
   input  logic [ADDR_W-1:0]  pcTarget_in,
   output logic               memReq_out,
   output logic [ADDR_W-1:0]  memAddr_out,
   input  logic               memValid_in,
   input  logic [INST_W-1:0]  memInst_in,
   output logic               IF_stallReq_out,
   output logic               instE_out,
   output logic [ADDR_W-1:0]  pc_out,
   output logic [INST_W-1:0]  inst_out,
   output logic               IF_taken_out,
   output logic [ADDR_W-1:0]  IF_pcPred_out,
   input  logic               bpUpdE_in,
   input  logic [ADDR_W-1:0]  bpUpdPc_in,
   input  logic               bpUpdTaken_in,
   output logic [1:0]         state_dbg_out
);

   // Handshake: memReq_out/memAddr_out are held stable from issue until the
   // single-cycle memValid_in pulse that carries memInst_in; a request is
   // never withdrawn early except by a redirect, after which the late
   // response is still awaited (DROP) and discarded.

   if_state_e         r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic              r_mem_req, w_mem_req_nxt;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
   logic              r_inst_e, w_inst_e_nxt;
   logic [ADDR_W-1:0] r_pc_o, w_pc_o_nxt;
   logic [INST_W-1:0] r_inst_o, w_inst_o_nxt;
   logic              r_taken, w_taken_nxt;
   logic [ADDR_W-1:0] r_pred, w_pred_nxt;
   logic              w_pred_taken;
   logic [ADDR_W-1:0] w_pred_pc;
   logic              w_unused_stall;

`ifdef IF_BPRED_EN
   if_bpred #(
      .BHT_IDX_W (BHT_IDX_W)
   ) u_bpred (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .rdy_in       (rdy_in),
      .pc_in        (r_pc),
      .inst_in      (memInst_in),
      .upd_e_in     (bpUpdE_in),
      .upd_pc_in    (bpUpdPc_in),
      .upd_taken_in (bpUpdTaken_in),
      .taken_out    (w_pred_taken),
      .pred_pc_out  (w_pred_pc)
   );
`else
   logic w_unused_bp;
   assign w_unused_bp  = ^{bpUpdE_in, bpUpdPc_in, bpUpdTaken_in, (BHT_IDX_W > 0)};
   assign w_pred_taken = 1'b0;
   assign w_pred_pc    = r_pc + 32'd4;
`endif

   // Only the IF bit of the stall vector matters here.
   assign w_unused_stall = ^stall_in;

   // Next-state and next-register values; a redirect overrides everything.
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_mem_req_nxt  = r_mem_req;
      w_mem_addr_nxt = r_mem_addr;
      w_inst_e_nxt   = r_inst_e;
      w_pc_o_nxt     = r_pc_o;
      w_inst_o_nxt   = r_inst_o;
      w_taken_nxt    = r_taken;
      w_pred_nxt     = r_pred;

      case (r_state)
         IF_IDLE: begin
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = word_align(r_pc);
            w_state_nxt    = IF_WAIT;
         end
         IF_WAIT: begin
            if (memValid_in) begin
               w_mem_req_nxt = 1'b0;
               w_inst_o_nxt  = memInst_in;
               w_pc_o_nxt    = r_pc;
               w_taken_nxt   = w_pred_taken;
               w_pred_nxt    = w_pred_pc;
               w_inst_e_nxt  = 1'b1;
               w_state_nxt   = IF_HOLD;
            end
         end
         IF_HOLD: begin
            if (stall_in[STALL_IF_BIT] != STALL) begin
               w_pc_nxt     = r_pred;
               w_inst_e_nxt = 1'b0;
               w_state_nxt  = IF_IDLE;
            end
         end
         IF_DROP: begin
            w_mem_req_nxt = 1'b0;
            if (memValid_in) w_state_nxt = IF_IDLE;
         end
         default: w_state_nxt = IF_IDLE;
      endcase

      if (pcJump_in == JUMP) begin
         w_pc_nxt = pcTarget_in;
         if (r_state == IF_DROP) begin
            w_mem_req_nxt = r_mem_req;
            w_state_nxt   = IF_DROP;
         end else begin
            w_mem_req_nxt  = 1'b0;
            w_mem_addr_nxt = r_mem_addr;
            w_inst_e_nxt   = 1'b0;
            w_taken_nxt    = 1'b0;
            w_pc_o_nxt     = r_pc_o;
            w_inst_o_nxt   = r_inst_o;
            w_pred_nxt     = r_pred;
            w_state_nxt    = ((r_state == IF_WAIT) && !memValid_in) ? IF_DROP : IF_IDLE;
         end
      end
   end

   // State register; rdy_in low freezes it.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)   r_state <= IF_IDLE;
      else if (rdy_in) r_state <= w_state_nxt;
   end

   // PC, memory request and output buffer registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_pc       <= RESET_PC;
         r_mem_req  <= DISABLE;
         r_mem_addr <= ZERO32;
         r_inst_e   <= 1'b0;
         r_pc_o     <= ZERO32;
         r_inst_o   <= ZERO32;
         r_taken    <= 1'b0;
         r_pred     <= ZERO32;
      end else if (rdy_in) begin
         r_pc       <= w_pc_nxt;
         r_mem_req  <= w_mem_req_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_inst_e   <= w_inst_e_nxt;
         r_pc_o     <= w_pc_o_nxt;
         r_inst_o   <= w_inst_o_nxt;
         r_taken    <= w_taken_nxt;
         r_pred     <= w_pred_nxt;
      end
   end

   assign memReq_out      = r_mem_req;
   assign memAddr_out     = r_mem_addr;
   assign IF_stallReq_out = (r_state == IF_WAIT) || (r_state == IF_DROP);
   assign instE_out       = r_inst_e;
   assign pc_out          = r_pc_o;
   assign inst_out        = r_inst_o;
   assign IF_taken_out    = r_taken;
   assign IF_pcPred_out   = r_pred;
   assign state_dbg_out   = r_state;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: the bench plays the memory controller and EX stage.
// The reference model tracks only the architectural PC of the next fetch
// (sequential +4 or redirect target) and derives every expected output from it.
module tb_if_fetch;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic [5:0]  stall_in;
   logic        pcJump_in;
   logic [31:0] pcTarget_in;
   logic        memReq_out;
   logic [31:0] memAddr_out;
   logic        memValid_in;
   logic [31:0] memInst_in;
   logic        IF_stallReq_out;
   logic        instE_out;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic        IF_taken_out;
   logic [31:0] IF_pcPred_out;
   logic        bpUpdE_in;
   logic [31:0] bpUpdPc_in;
   logic        bpUpdTaken_in;
   logic [1:0]  state_dbg_out;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_pc;

   if_fetch dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .rdy_in          (rdy_in),
      .stall_in        (stall_in),
      .pcJump_in       (pcJump_in),
      .pcTarget_in     (pcTarget_in),
      .memReq_out      (memReq_out),
      .memAddr_out     (memAddr_out),
      .memValid_in     (memValid_in),
      .memInst_in      (memInst_in),
      .IF_stallReq_out (IF_stallReq_out),
      .instE_out       (instE_out),
      .pc_out          (pc_out),
      .inst_out        (inst_out),
      .IF_taken_out    (IF_taken_out),
      .IF_pcPred_out   (IF_pcPred_out),
      .bpUpdE_in       (bpUpdE_in),
      .bpUpdPc_in      (bpUpdPc_in),
      .bpUpdTaken_in   (bpUpdTaken_in),
      .state_dbg_out   (state_dbg_out)
   );

   // clock / reset
   always #5 clk_in = ~clk_in;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (memReq_out === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Memory answers lat cycles after being sampled, with a one-cycle pulse.
   task automatic mem_return(input int lat, input logic [31:0] inst);
      repeat (lat - 1) tick();
      memValid_in = 1'b1;
      memInst_in  = inst;
      tick();
      memValid_in = 1'b0;
      memInst_in  = $urandom;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] v;
      v      = $urandom;
      v[6:0] = 7'b0010011;
      return v;
   endfunction

   // scenarios
   task automatic test_reset();
      rst_n_in = 1'b0; rdy_in = 1'b1; stall_in = '0; pcJump_in = 1'b0;
      pcTarget_in = '0; memValid_in = 1'b0; memInst_in = '0;
      bpUpdE_in = 1'b0; bpUpdPc_in = '0; bpUpdTaken_in = 1'b0;
      tick(); tick();
      n_vec++;
      if ({memReq_out, memAddr_out, IF_stallReq_out, instE_out, pc_out, inst_out,
           IF_taken_out, IF_pcPred_out} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got req=%b addr=%h stl=%b e=%b pc=%h inst=%h tk=%b pred=%h want all 0",
                  memReq_out, memAddr_out, IF_stallReq_out, instE_out, pc_out, inst_out,
                  IF_taken_out, IF_pcPred_out);
      end
      rst_n_in = 1'b1;
      exp_pc   = 32'h0;
   endtask

   task automatic test_basic_fetch();
      bit ok;
      wait_req(ok);
      n_vec++;
      if (!ok || memAddr_out !== 32'h0 || IF_stallReq_out !== 1'b1) begin
         n_err++;
         $display("FAIL first_req: ok=%b addr=%h stl=%b want ok=1 addr=0 stl=1", ok, memAddr_out, IF_stallReq_out);
      end
      mem_return(2, 32'h0000_0013);
      n_vec++;
      if ({instE_out, pc_out, inst_out, IF_taken_out, IF_pcPred_out, memReq_out} !==
          {1'b1, 32'h0, 32'h13, 1'b0, 32'h4, 1'b0}) begin
         n_err++;
         $display("FAIL first_capture: e=%b pc=%h inst=%h tk=%b pred=%h req=%b want 1 0 13 0 4 0",
                  instE_out, pc_out, inst_out, IF_taken_out, IF_pcPred_out, memReq_out);
      end
      tick();
      n_vec++;
      if (instE_out !== 1'b0 || memReq_out !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_hold: e=%b req=%b want 0 0", instE_out, memReq_out);
      end
      wait_req(ok);
      exp_pc = 32'h4;
      n_vec++;
      if (!ok || memAddr_out !== exp_pc) begin
         n_err++;
         $display("FAIL second_req: ok=%b addr=%h want %h", ok, memAddr_out, exp_pc);
      end
   endtask

   task automatic test_stall();
      bit ok;
      logic [31:0] inst;
      inst = rand_inst();
      mem_return(2, inst);
      stall_in = 6'b000010 | 6'($urandom_range(0, 63));
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if ({instE_out, pc_out, inst_out, IF_pcPred_out, memReq_out} !==
             {1'b1, exp_pc, inst, exp_pc + 32'd4, 1'b0}) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: e=%b pc=%h inst=%h pred=%h req=%b want 1 %h %h %h 0",
                     i, instE_out, pc_out, inst_out, IF_pcPred_out, memReq_out, exp_pc, inst, exp_pc + 32'd4);
         end
      end
      stall_in = 6'($urandom_range(0, 63)) & 6'b111101;
      tick();
      n_vec++;
      if (instE_out !== 1'b0 || memReq_out !== 1'b0) begin
         n_err++;
         $display("FAIL stall_release_idle: e=%b req=%b want 0 0", instE_out, memReq_out);
      end
      tick();
      exp_pc = exp_pc + 32'd4;
      n_vec++;
      if (memReq_out !== 1'b1 || memAddr_out !== exp_pc) begin
         n_err++;
         $display("FAIL stall_next_req: req=%b addr=%h want 1 %h", memReq_out, memAddr_out, exp_pc);
      end
      stall_in = '0;
   endtask

   task automatic test_jump_drop();
      bit ok;
      tick();
      pcJump_in = 1'b1; pcTarget_in = 32'h100;
      tick();
      pcJump_in = 1'b0;
      n_vec++;
      if ({memReq_out, IF_stallReq_out, instE_out} !== 3'b010) begin
         n_err++;
         $display("FAIL drop_enter: req=%b stl=%b e=%b want 0 1 0", memReq_out, IF_stallReq_out, instE_out);
      end
      tick(); tick();
      n_vec++;
      if ({memReq_out, IF_stallReq_out, instE_out} !== 3'b010) begin
         n_err++;
         $display("FAIL drop_wait: req=%b stl=%b e=%b want 0 1 0", memReq_out, IF_stallReq_out, instE_out);
      end
      mem_return(1, rand_inst());
      n_vec++;
      if ({memReq_out, IF_stallReq_out, instE_out} !== 3'b000) begin
         n_err++;
         $display("FAIL drop_discard: req=%b stl=%b e=%b want 0 0 0", memReq_out, IF_stallReq_out, instE_out);
      end
      wait_req(ok);
      exp_pc = 32'h100;
      n_vec++;
      if (!ok || memAddr_out !== exp_pc) begin
         n_err++;
         $display("FAIL drop_next_req: ok=%b addr=%h want %h", ok, memAddr_out, exp_pc);
      end
   endtask

   task automatic test_jump_same_cycle();
      bit ok;
      pcJump_in = 1'b1; pcTarget_in = 32'h200;
      memValid_in = 1'b1; memInst_in = rand_inst();
      tick();
      pcJump_in = 1'b0; memValid_in = 1'b0;
      n_vec++;
      if ({memReq_out, IF_stallReq_out, instE_out} !== 3'b000) begin
         n_err++;
         $display("FAIL jump_valid_idle: req=%b stl=%b e=%b want 0 0 0", memReq_out, IF_stallReq_out, instE_out);
      end
      tick();
      exp_pc = 32'h200;
      n_vec++;
      if (memReq_out !== 1'b1 || memAddr_out !== exp_pc) begin
         n_err++;
         $display("FAIL jump_valid_next_req: req=%b addr=%h want 1 %h", memReq_out, memAddr_out, exp_pc);
      end
      wait_req(ok);
   endtask

   task automatic test_rdy_and_async_reset();
      bit ok;
      logic [31:0] inst;
      rdy_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         memValid_in = (i == 1);
         memInst_in  = $urandom;
         tick();
         n_vec++;
         if ({memReq_out, memAddr_out, instE_out, IF_stallReq_out} !== {1'b1, exp_pc, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL rdy_freeze[%0d]: req=%b addr=%h e=%b stl=%b want 1 %h 0 1",
                     i, memReq_out, memAddr_out, instE_out, IF_stallReq_out, exp_pc);
         end
      end
      memValid_in = 1'b0;
      rdy_in = 1'b1;
      inst = rand_inst();
      mem_return(1, inst);
      n_vec++;
      if ({instE_out, pc_out, inst_out, IF_pcPred_out} !== {1'b1, exp_pc, inst, exp_pc + 32'd4}) begin
         n_err++;
         $display("FAIL rdy_resume: e=%b pc=%h inst=%h pred=%h want 1 %h %h %h",
                  instE_out, pc_out, inst_out, IF_pcPred_out, exp_pc, inst, exp_pc + 32'd4);
      end
      wait_req(ok);
      exp_pc = exp_pc + 32'd4;
      n_vec++;
      if (!ok || memAddr_out !== exp_pc) begin
         n_err++;
         $display("FAIL rdy_next_req: ok=%b addr=%h want %h", ok, memAddr_out, exp_pc);
      end
      #2 rst_n_in = 1'b0;
      #1;
      n_vec++;
      if ({memReq_out, memAddr_out, IF_stallReq_out, instE_out, pc_out, inst_out,
           IF_taken_out, IF_pcPred_out} !== '0) begin
         n_err++;
         $display("FAIL async_reset: req=%b addr=%h stl=%b e=%b pc=%h pred=%h want all 0",
                  memReq_out, memAddr_out, IF_stallReq_out, instE_out, pc_out, IF_pcPred_out);
      end
      tick();
      rst_n_in = 1'b1;
      exp_pc = 32'h0;
      wait_req(ok);
      n_vec++;
      if (!ok || memAddr_out !== exp_pc) begin
         n_err++;
         $display("FAIL post_reset_req: ok=%b addr=%h want %h", ok, memAddr_out, exp_pc);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      logic [31:0] inst;
      pcJump_in = 1'b1; pcTarget_in = 32'hFFFF_FFFC;
      tick();
      pcJump_in = 1'b0;
      mem_return(1, rand_inst());
      wait_req(ok);
      n_vec++;
      if (!ok || memAddr_out !== 32'hFFFF_FFFC) begin
         n_err++;
         $display("FAIL wrap_req: ok=%b addr=%h want fffffffc", ok, memAddr_out);
      end
      inst = rand_inst();
      mem_return(2, inst);
      n_vec++;
      if ({instE_out, pc_out, IF_pcPred_out} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
         n_err++;
         $display("FAIL wrap_pred: e=%b pc=%h pred=%h want 1 fffffffc 0", instE_out, pc_out, IF_pcPred_out);
      end
      wait_req(ok);
      exp_pc = 32'h0;
      n_vec++;
      if (!ok || memAddr_out !== exp_pc) begin
         n_err++;
         $display("FAIL wrap_next_req: ok=%b addr=%h want 0", ok, memAddr_out);
      end
   endtask

   task automatic test_random();
      bit          ok;
      int          kind, lat, ns;
      logic [31:0] inst, tgt;
      for (int it = 0; it < 40; it++) begin
         wait_req(ok);
         n_vec++;
         if (!ok || memAddr_out !== (exp_pc & ~32'h3)) begin
            n_err++;
            $display("FAIL rnd_req[%0d]: ok=%b addr=%h want %h", it, ok, memAddr_out, exp_pc & ~32'h3);
         end
         kind = $urandom_range(0, 5);
         lat  = $urandom_range(1, 4);
         tgt  = $urandom;
         inst = rand_inst();
         if (kind == 0) begin
            repeat ($urandom_range(0, 2)) tick();
            pcJump_in = 1'b1; pcTarget_in = tgt;
            tick();
            pcJump_in = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            mem_return(1, inst);
            n_vec++;
            if ({memReq_out, IF_stallReq_out, instE_out} !== 3'b000) begin
               n_err++;
               $display("FAIL rnd_drop[%0d]: req=%b stl=%b e=%b want 0 0 0", it, memReq_out, IF_stallReq_out, instE_out);
            end
            exp_pc = tgt;
         end else if (kind == 1) begin
            repeat (lat - 1) tick();
            pcJump_in = 1'b1; pcTarget_in = tgt;
            memValid_in = 1'b1; memInst_in = inst;
            tick();
            pcJump_in = 1'b0; memValid_in = 1'b0;
            n_vec++;
            if ({memReq_out, IF_stallReq_out, instE_out} !== 3'b000) begin
               n_err++;
               $display("FAIL rnd_jump_valid[%0d]: req=%b stl=%b e=%b want 0 0 0", it, memReq_out, IF_stallReq_out, instE_out);
            end
            exp_pc = tgt;
         end else begin
            mem_return(lat, inst);
            n_vec++;
            if ({instE_out, pc_out, inst_out, IF_taken_out, IF_pcPred_out} !==
                {1'b1, exp_pc, inst, 1'b0, exp_pc + 32'd4}) begin
               n_err++;
               $display("FAIL rnd_capture[%0d]: e=%b pc=%h inst=%h tk=%b pred=%h want 1 %h %h 0 %h",
                        it, instE_out, pc_out, inst_out, IF_taken_out, IF_pcPred_out, exp_pc, inst, exp_pc + 32'd4);
            end
            ns = $urandom_range(0, 3);
            stall_in = 6'b000010;
            for (int s = 0; s < ns; s++) begin
               tick();
               n_vec++;
               if ({instE_out, pc_out, memReq_out} !== {1'b1, exp_pc, 1'b0}) begin
                  n_err++;
                  $display("FAIL rnd_stall[%0d]: e=%b pc=%h req=%b want 1 %h 0", it, instE_out, pc_out, memReq_out, exp_pc);
               end
            end
            stall_in = '0;
            if (kind == 2) begin
               pcJump_in = 1'b1; pcTarget_in = tgt;
               stall_in = 6'($urandom_range(0, 63));
               tick();
               pcJump_in = 1'b0; stall_in = '0;
               n_vec++;
               if ({instE_out, IF_taken_out, memReq_out} !== 3'b000) begin
                  n_err++;
                  $display("FAIL rnd_hold_jump[%0d]: e=%b tk=%b req=%b want 0 0 0", it, instE_out, IF_taken_out, memReq_out);
               end
               exp_pc = tgt;
            end else begin
               exp_pc = exp_pc + 32'd4;
            end
         end
      end
   endtask

`ifdef IF_BPRED_EN
   task automatic test_bpred();
      bit ok;
      logic [31:0] bne, jal;
      bne = {1'b1, 6'b111111, 5'd2, 5'd1, 3'b001, 4'b1000, 1'b1, 7'b1100011};
      jal = {1'b0, 10'b0000000100, 1'b0, 8'h00, 5'd1, 7'b1101111};
      wait_req(ok);
      bpUpdE_in = 1'b1; bpUpdPc_in = 32'h40; bpUpdTaken_in = 1'b1;
      pcJump_in = 1'b1; pcTarget_in = 32'h40;
      tick();
      pcJump_in = 1'b0;
      tick();
      bpUpdE_in = 1'b0;
      mem_return(1, rand_inst());
      wait_req(ok);
      mem_return(2, bne);
      n_vec++;
      if ({instE_out, pc_out, IF_taken_out, IF_pcPred_out} !== {1'b1, 32'h40, 1'b1, 32'h30}) begin
         n_err++;
         $display("FAIL bpred_bne: e=%b pc=%h tk=%b pred=%h want 1 40 1 30", instE_out, pc_out, IF_taken_out, IF_pcPred_out);
      end
      pcJump_in = 1'b1; pcTarget_in = 32'h50;
      tick();
      pcJump_in = 1'b0;
      wait_req(ok);
      mem_return(1, jal);
      n_vec++;
      if ({instE_out, pc_out, IF_taken_out, IF_pcPred_out} !== {1'b1, 32'h50, 1'b1, 32'h58}) begin
         n_err++;
         $display("FAIL bpred_jal: e=%b pc=%h tk=%b pred=%h want 1 50 1 58", instE_out, pc_out, IF_taken_out, IF_pcPred_out);
      end
   endtask
`endif

   // sequence and final report
   initial begin
      test_reset();
      test_basic_fetch();
      test_stall();
      test_jump_drop();
      test_jump_same_cycle();
      test_rdy_and_async_reset();
      test_wrap();
      test_random();
`ifdef IF_BPRED_EN
      test_bpred();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
